// File: rtl/FullAdder.sv
// One-bit full adder cell.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module FullAdder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic res,
    output logic cout
);
    assign res  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));
endmodule

// File: rtl/bsa_defs.vh
`ifndef BSA_DEFS_VH
`define BSA_DEFS_VH
localparam logic [1:0] ST_IDLE = 2'd0;
localparam logic [1:0] ST_RUN  = 2'd1;
localparam logic [1:0] ST_DONE = 2'd2;
`endif

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial add/subtract around one FullAdder cell.
// Latency: WIDTH RUN cycles after the start edge; done pulses the cycle after.
// Backpressure: start is ignored while busy; a start in the done cycle chains back-to-back.
module bit_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    `include "bsa_defs.vh"

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

    logic [1:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_res, fa_cout;
    logic             load, run, last;

    FullAdder u_fa (
        .x    (opa_q[0]),
        .y    (opb_q[0]),
        .cin  (carry_q),
        .res  (fa_res),
        .cout (fa_cout)
    );

    assign run  = (state_q == ST_RUN);
    assign last = run && (cnt_q == CNT_LAST);
    assign load = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && (start == 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Only a definite 1 on start leaves IDLE/DONE, so an X start cannot reach state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start == 1'b1) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
            ST_DONE: if (start == 1'b1) state_d = ST_RUN;
                     else               state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_comb begin
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (load) begin
            opa_d   = a;
            opb_d   = sub ? ~b : b;
            carry_d = sub ? 1'b1 : cin;
            cnt_d   = '0;
        end else if (run) begin
            opa_d   = {1'b0, opa_q[WIDTH-1:1]};
            opb_d   = {1'b0, opb_q[WIDTH-1:1]};
            acc_d   = {fa_res, acc_q[WIDTH-1:1]};
            carry_d = fa_cout;
            if (!last) cnt_d = cnt_q + CW'(1);
            // Carry into the MSB, needed for signed overflow on the final bit.
            if (cnt_q == CNT_MSB) cmsb_d = fa_cout;
            if (last) begin
                sum_d  = {fa_res, acc_q[WIDTH-1:1]};
                cout_d = fa_cout;
                ovf_d  = cmsb_q ^ fa_cout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder at WIDTH=16.
module tb_bit_serial_adder;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    bit_serial_adder #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives start there and waits for done (bounded).
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic ts, input logic tc, input int repulse,
                          input logic [15:0] es, input logic ec, input logic eo);
        int          lat;
        int          bcnt;
        bit          stable;
        logic [15:0] prev;
        prev  = sum;
        a     = ta;
        b     = tb_v;
        sub   = ts;
        cin   = tc;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        lat    = 1;
        bcnt   = 0;
        stable = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            if (sum !== prev) stable = 1'b0;
            if (lat == repulse) begin
                start = 1'b1;
                a     = ~ta;
                b     = 16'h5A5A;
                sub   = ~ts;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
        chk({tag, "_lat"},    32'(lat),      32'd17);
        chk({tag, "_busy"},   32'(bcnt),     32'd16);
        chk({tag, "_stable"}, 32'(stable),   32'd1);
        chk({tag, "_sum"},    32'(sum),      32'(es));
        chk({tag, "_cout"},   32'(cout),     32'(ec));
        chk({tag, "_ovf"},    32'(overflow), 32'(eo));
    endtask

    initial begin
        logic [15:0] ra, rb, bb, rsum;
        logic        rs, rc, rovf;
        logic [16:0] full;

        rst_n = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy),     32'd0);
        chk("rst_done", 32'(done),     32'd0);
        chk("rst_sum",  32'(sum),      32'd0);
        chk("rst_cout", 32'(cout),     32'd0);
        chk("rst_ovf",  32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0, 1'b0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
        @(negedge clk);
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b0, 0, 16'hFFFE, 1'b0, 1'b0);
        @(negedge clk);
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 1'b0, 0, 16'h7FFF, 1'b1, 1'b1);
        @(negedge clk);
        run_op("add_cin",   16'h00FF, 16'h0001, 1'b0, 1'b1, 0, 16'h0101, 1'b0, 1'b0);
        @(negedge clk);
        run_op("sub_cin",   16'h0010, 16'h0010, 1'b1, 1'b1, 0, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);

        // Mid-run start pulse must be ignored; the next op chains straight from DONE.
        run_op("repulse",   16'h1111, 16'h2222, 1'b0, 1'b0, 5, 16'h3333, 1'b0, 1'b0);
        run_op("b2b",       16'h0100, 16'h0200, 1'b0, 1'b0, 0, 16'h0300, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_idle_done", 32'(done), 32'd0);

        a     = 16'hAAAA;
        b     = 16'h1111;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy),     32'd0);
        chk("arst_done", 32'(done),     32'd0);
        chk("arst_sum",  32'(sum),      32'd0);
        chk("arst_cout", 32'(cout),     32'd0);
        chk("arst_ovf",  32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst",  16'h0001, 16'h0001, 1'b0, 1'b0, 0, 16'h0002, 1'b0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rs   = 1'($urandom);
            rc   = 1'($urandom);
            bb   = rs ? ~rb : rb;
            full = {1'b0, ra} + {1'b0, bb} + 17'(rs ? 1'b1 : rc);
            rsum = full[15:0];
            rovf = (ra[15] == bb[15]) && (rsum[15] != ra[15]);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
            run_op("rnd", ra, rb, rs, rc, 0, rsum, full[16], rovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Multi-cycle, LSB-first bit-serial adder/subtractor built around one instance of the existing FullAdder cell.
- Sits directly upstream of FullAdder: it shifts one operand bit pair per clock into the cell's x/y inputs, feeds cin from a carry flop, and collects res/cout back.
- Serves as the low-area add path for the CAP17 datapath, with a start/done handshake toward the control unit.

Parameters:
- WIDTH, 16, operand and result width in bits (>=2).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE or DONE.
- sub  input  1  1 = a - b, 0 = a + b + cin; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in for add; ignored when sub=1.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, result valid.
- sum  output  WIDTH  result register.
- cout  output  1  carry out of MSB.
- overflow  output  1  signed overflow.

Behaviour:
- Reset: async assert when rst_n=0. state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, all internal shift/count/carry registers 0.
- State machine: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 at an edge loads opA<=a and opB<=(sub ? ~b : b).
  - Same edge loads carry<=(sub ? 1 : cin), cnt<=0, then goes to RUN.
  - start=0: stay in IDLE.
- RUN:
  - FullAdder inputs: x=opA[0], y=opB[0], cin=carry.
  - Each edge: opA and opB shift right by one; res shifts into acc MSB (acc shifts right); carry<=FullAdder cout; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-2: save carry (carry into MSB) into cmsb.
  - On the edge where cnt==WIDTH-1: sum<=final acc including this res bit; cout<=FullAdder cout; overflow<=cmsb XOR FullAdder cout; go to DONE.
  - start is ignored in RUN (no queuing, no restart).
- DONE:
  - done=1 for exactly this cycle.
  - start=1 here loads a new operation as in IDLE and goes to RUN (back-to-back).
  - Otherwise go to IDLE.
- Latency: start edge E0 → WIDTH RUN edges E1..EW → done high in the cycle after EW. Throughput is one result per WIDTH+1 cycles.
- Result persistence: sum, cout and overflow change only on the final RUN edge. They hold their value through IDLE and through the next operation until it completes.
- busy = (state==RUN), registered decode.
- cnt width: $clog2(WIDTH) bits. It never wraps, because RUN exits at WIDTH-1.
- Subtract semantics: sum = a + ~b + 1. cout=1 means no borrow (a >= b unsigned).
- Reset mid-operation: abort immediately. All outputs return to reset values; the previous result is lost.
- X on start or operands outside the sampling states must not propagate into state.

Decomposition:
- Shared include file bsa_defs.vh holds the state localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2). No other shared constants.
- One sub-module: the existing FullAdder instantiated once (ports x, y, cin, res, cout). All sequencing stays in bit_serial_adder; no further hierarchy.

Test Plan (WIDTH=16):
- Basic add: a=0x1234, b=0x4321, sub=0, cin=0, start for 1 cycle → busy high for 16 cycles; done pulses in cycle 17 after the start edge; sum=0x5555, cout=0, overflow=0.
- Carry chain: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1, overflow=0. Also a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, overflow=1.
- Subtract: sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, overflow=0. Also a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, overflow=1.
- Handshake:
  - Re-pulse start with different operands at RUN cycle 5 → ignored; first result is unchanged.
  - Start held high in the DONE cycle → new operation begins immediately, with no IDLE cycle between.
  - sum stays stable during the second RUN until its own final edge.
- Async reset: drop rst_n mid-RUN (cycle 8), asynchronously from clk → busy, done, sum, cout and overflow go to 0 without waiting for a clock edge. After release, a fresh 0x0001+0x0001 yields 0x0002.
- Random: 1000 random a/b/cin/sub operations vs. a reference model → every sum, cout and overflow matches; exactly one done per start accepted.
